ad9911_cfg_sequencer: RTL and testbench

- Takes one DDS profile update request (channel select, frequency, phase, amplitude) over a valid/ready handshake.
- Expands the request into an ordered series of single-register writes to the AD9911 SPI register writer: CSR, CTW0, CPOW0, ACR.
- Drives the writer's TR/REG_ADDR/DATA_IN and tracks completion via its OVER (chip-select-idle) output.
- Sits between the signal-generation control logic and the SPI writer; adds per-transaction timeout and error reporting.

---
 rtl/ad9911_pkg.sv | 34 +++
 rtl/ad9911_field_mux.sv | 39 +++
 rtl/ad9911_cfg_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ad9911_cfg_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9911_pkg.sv
// Shared register map, request-mask field indices and sequencer state encoding
// for the AD9911 configuration sequencer.
package ad9911_pkg;

  localparam logic [7:0] ADDR_CSR   = 8'h00;
  localparam logic [7:0] ADDR_CTW0  = 8'h04;
  localparam logic [7:0] ADDR_CPOW0 = 8'h05;
  localparam logic [7:0] ADDR_ACR   = 8'h06;

  localparam logic [1:0] FIELD_CSR   = 2'd0;
  localparam logic [1:0] FIELD_CTW0  = 2'd1;
  localparam logic [1:0] FIELD_CPOW0 = 2'd2;
  localparam logic [1:0] FIELD_ACR   = 2'd3;

  localparam logic [4:0] ACR_ASF_LSB    = 5'd0;
  localparam logic [4:0] ACR_AMP_EN_BIT = 5'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP
  } seq_state_t;

  function automatic logic [31:0] acr_word(input logic [9:0] asf, input logic amp_en);
    logic [31:0] w;
    w = '0;
    w[ACR_ASF_LSB +: 10] = asf;
    w[ACR_AMP_EN_BIT]    = amp_en;
    return w;
  endfunction

endpackage

// File: rtl/ad9911_field_mux.sv
// Picks the lowest pending field of a profile request and produces its register
// address, right-aligned data word and the mask with that field removed.
module ad9911_field_mux
  import ad9911_pkg::*;
#(
  parameter logic [7:0] CSR_VALUE = 8'h10
) (
  input  logic [3:0]  pend_mask,
  input  logic [31:0] ftw,
  input  logic [13:0] pow,
  input  logic [9:0]  asf,
  input  logic        amp_en,
  output logic [7:0]  sel_addr,
  output logic [31:0] sel_data,
  output logic [3:0]  rest_mask
);

  always_comb begin
    sel_addr  = ADDR_CSR;
    sel_data  = {24'd0, CSR_VALUE};
    rest_mask = pend_mask;
    if (pend_mask[FIELD_CSR]) begin
      rest_mask[FIELD_CSR] = 1'b0;
    end else if (pend_mask[FIELD_CTW0]) begin
      sel_addr              = ADDR_CTW0;
      sel_data              = ftw;
      rest_mask[FIELD_CTW0] = 1'b0;
    end else if (pend_mask[FIELD_CPOW0]) begin
      sel_addr               = ADDR_CPOW0;
      sel_data               = {18'd0, pow};
      rest_mask[FIELD_CPOW0] = 1'b0;
    end else if (pend_mask[FIELD_ACR]) begin
      sel_addr             = ADDR_ACR;
      sel_data             = acr_word(asf, amp_en);
      rest_mask[FIELD_ACR] = 1'b0;
    end
  end

endmodule

// File: rtl/ad9911_cfg_sequencer.sv
// AD9911 profile-update sequencer: expands one request into ordered single-register
// SPI writes (CSR, CTW0, CPOW0, ACR) with a per-transaction timeout.
module ad9911_cfg_sequencer
  import ad9911_pkg::*;
#(
  parameter logic [7:0] CSR_VALUE      = 8'h10,
  parameter int         GAP_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_MASK,
  input  logic [31:0] REQ_FTW,
  input  logic [13:0] REQ_POW,
  input  logic [9:0]  REQ_ASF,
  input  logic        REQ_AMP_EN,
  output logic        SPI_TR,
  output logic [7:0]  SPI_REG_ADDR,
  output logic [31:0] SPI_DATA,
  input  logic        SPI_OVER,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic        ERR_STICKY
);

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_t  state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] ftw_q, ftw_d;
  logic [13:0] pow_q, pow_d;
  logic [9:0]  asf_q, asf_d;
  logic        amp_en_q, amp_en_d;
  logic        tr_d, done_d, error_d, sticky_d;
  logic [7:0]  addr_d;
  logic [31:0] data_d;
  logic        timed_out;

  logic [7:0]  mux_addr;
  logic [31:0] mux_data;
  logic [3:0]  mux_rest;

  ad9911_field_mux #(
    .CSR_VALUE (CSR_VALUE)
  ) u_field_mux (
    .pend_mask (mask_q),
    .ftw       (ftw_q),
    .pow       (pow_q),
    .asf       (asf_q),
    .amp_en    (amp_en_q),
    .sel_addr  (mux_addr),
    .sel_data  (mux_data),
    .rest_mask (mux_rest)
  );

  assign REQ_READY = (state_q == ST_IDLE);
  assign BUSY      = (state_q != ST_IDLE);
  assign timed_out = (cnt_q == TO_LAST);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    ftw_d    = ftw_q;
    pow_d    = pow_q;
    asf_d    = asf_q;
    amp_en_d = amp_en_q;
    tr_d     = SPI_TR;
    addr_d   = SPI_REG_ADDR;
    data_d   = SPI_DATA;
    done_d   = 1'b0;
    error_d  = 1'b0;
    sticky_d = ERR_STICKY;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          ftw_d    = REQ_FTW;
          pow_d    = REQ_POW;
          asf_d    = REQ_ASF;
          amp_en_d = REQ_AMP_EN;
          mask_d   = REQ_MASK;
          sticky_d = 1'b0;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (mask_q == 4'd0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = mux_addr;
          data_d  = mux_data;
          mask_d  = mux_rest;
          tr_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      // Writer acknowledges a transfer by pulling chip select low.
      ST_ISSUE: begin
        if (!SPI_OVER) begin
          tr_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end else if (timed_out) begin
          tr_d     = 1'b0;
          error_d  = 1'b1;
          sticky_d = 1'b1;
          mask_d   = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (SPI_OVER) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ST_SELECT : ST_GAP;
        end else if (timed_out) begin
          error_d  = 1'b1;
          sticky_d = 1'b1;
          mask_d   = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_SELECT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      cnt_q        <= '0;
      ftw_q        <= '0;
      pow_q        <= '0;
      asf_q        <= '0;
      amp_en_q     <= 1'b0;
      SPI_TR       <= 1'b0;
      SPI_REG_ADDR <= '0;
      SPI_DATA     <= '0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
      ERR_STICKY   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      ftw_q        <= ftw_d;
      pow_q        <= pow_d;
      asf_q        <= asf_d;
      amp_en_q     <= amp_en_d;
      SPI_TR       <= tr_d;
      SPI_REG_ADDR <= addr_d;
      SPI_DATA     <= data_d;
      DONE         <= done_d;
      ERROR        <= error_d;
      ERR_STICKY   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_ad9911_cfg_sequencer.sv
// Randomized self-checking bench for ad9911_cfg_sequencer with a behavioural
// SPI-writer model and a write-list reference model.
module tb_ad9911_cfg_sequencer;

  localparam int         GAP  = 2;
  localparam int         TMO  = 64;
  localparam logic [7:0] CSRV = 8'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_mask = '0;
  logic [31:0] req_ftw = '0;
  logic [13:0] req_pow = '0;
  logic [9:0]  req_asf = '0;
  logic        req_amp_en = 1'b0;
  logic        req_ready, spi_tr, spi_over, busy, done, error, err_sticky;
  logic [7:0]  spi_addr;
  logic [31:0] spi_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_rise_cyc = 0;
  int unstable = 0;
  bit stuck = 1'b0;
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];

  ad9911_cfg_sequencer #(
    .CSR_VALUE      (CSRV),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK          (clk),
    .RESET        (rst),
    .REQ_VALID    (req_valid),
    .REQ_READY    (req_ready),
    .REQ_MASK     (req_mask),
    .REQ_FTW      (req_ftw),
    .REQ_POW      (req_pow),
    .REQ_ASF      (req_asf),
    .REQ_AMP_EN   (req_amp_en),
    .SPI_TR       (spi_tr),
    .SPI_REG_ADDR (spi_addr),
    .SPI_DATA     (spi_data),
    .SPI_OVER     (spi_over),
    .BUSY         (busy),
    .DONE         (done),
    .ERROR        (error),
    .ERR_STICKY   (err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: each enabled field becomes one write, always in CSR, CTW0, CPOW0, ACR order.
  task automatic model_req(input logic [3:0] m, input logic [31:0] f, input logic [13:0] p,
                           input logic [9:0] a, input logic en);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        case (i)
          0: exp_q.push_back({8'h00, 24'd0, CSRV});
          1: exp_q.push_back({8'h04, f});
          2: exp_q.push_back({8'h05, 32'(p)});
          default: exp_q.push_back({8'h06, 32'(a) + (en ? 32'd4096 : 32'd0)});
        endcase
      end
    end
  endtask

  task automatic ep_wait(input int n, input logic [39:0] cur);
    for (int k = 0; k < n; k++) begin
      if (rst) break;
      @(negedge clk);
      if (!rst && ({spi_addr, spi_data} !== cur)) unstable++;
    end
  endtask

  // SPI writer model: OVER falls some cycles after TR, rises again later.
  initial begin : spi_model
    logic [39:0] cur;
    spi_over = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && spi_tr && spi_over) begin
        cur = {spi_addr, spi_data};
        got_q.push_back(cur);
        ep_wait($urandom_range(0, 3), cur);
        if (!rst) spi_over = 1'b0;
        while (stuck && !rst) @(negedge clk);
        ep_wait($urandom_range(1, 6), cur);
        spi_over = 1'b1;
        last_rise_cyc = cyc;
      end
    end
  end

  task automatic send_req(input logic [3:0] m, input logic [31:0] f, input logic [13:0] p,
                          input logic [9:0] a, input logic en);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_mask = m; req_ftw = f; req_pow = p; req_asf = a; req_amp_en = en;
    model_req(m, f, p, a, en);
    while (!req_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_val("accept_wait", guard < 2000, 1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output int n_done, output int n_err,
                             output int done_cyc);
    int tail;
    n_done = 0; n_err = 0; done_cyc = -1; tail = 0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (error) n_err++;
      if (n_done + n_err > 0) begin
        tail++;
        if (tail > 4) break;
      end
      @(negedge clk);
    end
    check_val("finish_in_budget", (n_done + n_err) > 0, 1);
  endtask

  task automatic compare_writes(input string tag);
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val({tag, "_write"}, got_q[i], exp_q[i]);
    check_val({tag, "_stable"}, unstable, 0);
    exp_q.delete(); got_q.delete(); unstable = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int nd, ne, dcyc, ecyc, tfall, seen_tr;
    logic [39:0] lit [4];
    logic [3:0]  m;

    repeat (3) @(negedge clk);
    check_val("rst_ready", req_ready, 1);
    check_val("rst_tr", spi_tr, 0);
    check_val("rst_addr", spi_addr, 0);
    check_val("rst_data", spi_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_sticky", err_sticky, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full update with fixed values.
    send_req(4'hF, 32'h1234_5678, 14'h0ABC, 10'h3FF, 1'b1);
    wait_finish(500, nd, ne, dcyc);
    check_val("full_done", nd, 1);
    check_val("full_err", ne, 0);
    check_val("full_sticky", err_sticky, 0);
    lit = '{40'h00_0000_0010, 40'h04_1234_5678, 40'h05_0000_0ABC, 40'h06_0000_13FF};
    check_val("full_n", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check_val("full_lit", got_q[i], lit[i]);
    compare_writes("full");

    // Sparse mask: CTW0 then ACR, DONE timed from the last OVER rise.
    send_req(4'b1010, $urandom, 14'($urandom), 10'($urandom), 1'($urandom));
    wait_finish(500, nd, ne, dcyc);
    check_val("sparse_done", nd, 1);
    check_val("sparse_latency", dcyc - last_rise_cyc, GAP + 2);
    compare_writes("sparse");

    // Stuck writer: OVER never returns high.
    stuck = 1'b1;
    send_req(4'hF, $urandom, 14'($urandom), 10'($urandom), 1'b0);
    seen_tr = 0; tfall = -1; ecyc = -1; ne = 0; nd = 0;
    for (int k = 0; k < 300; k++) begin
      if (spi_tr) seen_tr = 1;
      else if (seen_tr != 0 && tfall < 0) tfall = cyc;
      if (error) begin
        ne++;
        if (ecyc < 0) ecyc = cyc;
      end
      if (done) nd++;
      @(negedge clk);
    end
    check_val("tmo_error_pulses", ne, 1);
    check_val("tmo_no_done", nd, 0);
    check_val("tmo_latency", ecyc - tfall, TMO);
    check_val("tmo_sticky", err_sticky, 1);
    check_val("tmo_idle", busy, 0);
    check_val("tmo_episodes", got_q.size(), 1);
    stuck = 1'b0;
    repeat (12) @(negedge clk);
    exp_q.delete(); got_q.delete(); unstable = 0;

    // Empty mask: clears sticky, DONE after one SELECT cycle, no SPI traffic.
    send_req(4'h0, $urandom, 14'($urandom), 10'($urandom), 1'b1);
    check_val("mask0_sticky_clr", err_sticky, 0);
    check_val("mask0_busy", busy, 1);
    check_val("mask0_no_early_done", done, 0);
    @(negedge clk);
    check_val("mask0_done", done, 1);
    check_val("mask0_ready", req_ready, 1);
    @(negedge clk);
    check_val("mask0_done_width", done, 0);
    repeat (4) @(negedge clk);
    compare_writes("mask0");

    // Back-to-back with VALID held; fields scrambled while busy.
    req_valid = 1'b1; req_mask = 4'b0111;
    req_ftw = $urandom; req_pow = 14'($urandom); req_asf = 10'($urandom); req_amp_en = 1'b1;
    model_req(req_mask, req_ftw, req_pow, req_asf, req_amp_en);
    @(posedge clk);
    @(negedge clk);
    nd = 0;
    while (!done && nd < 500) begin
      req_mask = 4'($urandom); req_ftw = $urandom; req_pow = 14'($urandom);
      req_asf = 10'($urandom); req_amp_en = 1'($urandom);
      @(negedge clk);
      nd++;
    end
    check_val("b2b_first_done", done, 1);
    check_val("b2b_ready_at_done", req_ready, 1);
    check_val("b2b_first_n", got_q.size(), 3);
    req_mask = 4'b1001; req_ftw = $urandom; req_pow = 14'($urandom);
    req_asf = 10'($urandom); req_amp_en = 1'b0;
    model_req(req_mask, req_ftw, req_pow, req_asf, req_amp_en);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check_val("b2b_second_accepted", busy, 1);
    wait_finish(500, nd, ne, dcyc);
    check_val("b2b_done", nd, 1);
    compare_writes("b2b");

    // Reset in the middle of the CTW0 transfer.
    send_req(4'h3, $urandom, 14'($urandom), 10'($urandom), 1'b1);
    for (int k = 0; k < 200 && !(spi_tr && spi_addr == 8'h04); k++) @(negedge clk);
    check_val("rst_mid_reached", spi_tr && spi_addr == 8'h04, 1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_mid_tr", spi_tr, 0);
    check_val("rst_mid_addr", spi_addr, 0);
    check_val("rst_mid_data", spi_data, 0);
    check_val("rst_mid_busy", busy, 0);
    check_val("rst_mid_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete(); got_q.delete(); unstable = 0;
    send_req(4'h1, $urandom, 14'($urandom), 10'($urandom), 1'b0);
    wait_finish(500, nd, ne, dcyc);
    check_val("post_rst_done", nd, 1);
    check_val("post_rst_err", ne, 0);
    compare_writes("post_rst");

    // Random requests.
    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      m = 4'($urandom);
      send_req(m, $urandom, 14'($urandom), 10'($urandom), 1'($urandom));
      wait_finish(500, nd, ne, dcyc);
      check_val("rand_done", nd, 1);
      check_val("rand_err", ne, 0);
      compare_writes("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
